// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB3-Lite encodings and bus width.
//   Exports AHB_DATA_W and the htrans/hresp/hsize/hburst field encodings.
package ahb_pkg;
  localparam int AHB_DATA_W = 32;
  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_e;
  typedef enum logic [1:0] {HR_OKAY, HR_ERROR, HR_RETRY, HR_SPLIT} hresp_e;
  typedef enum logic [2:0] {HS_BYTE, HS_HALF, HS_WORD, HS_DWORD, HS_4W, HS_8W, HS_16W, HS_32W} hsize_e;
  typedef enum logic [2:0] {HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4, HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16} hburst_e;
endpackage

// File: rtl/ahb_mem_slave_if.sv
// ahb_mem_slave_if: AHB3-Lite bus between one master and the memory slave.
//   master -> slave: HTRANS, HWRITE, HSIZE, HBURST, HADDR, HWDATA
//   slave -> master: HREADY, HRESP, HRDATA
interface ahb_mem_slave_if;
  import ahb_pkg::*;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [31:0]           HADDR;
  logic [AHB_DATA_W-1:0] HWDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;
  logic [AHB_DATA_W-1:0] HRDATA;
  modport master (output HTRANS, HWRITE, HSIZE, HBURST, HADDR, HWDATA, input HREADY, HRESP, HRDATA);
  modport slave  (input HTRANS, HWRITE, HSIZE, HBURST, HADDR, HWDATA, output HREADY, HRESP, HRDATA);
endinterface

// File: rtl/ahb_mem_slave_ram.sv
// ahb_mem_slave_ram: word-organised RAM, per-byte write enables, sync write, async read.
//   clk_i clock, we_i byte-lane enables, addr_i word index, wdata_i write word, rdata_o read word
module ahb_mem_slave_ram #(
  parameter  int DEPTH = 1024,
  localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem[addr_i];
endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB3-Lite memory slave with configurable wait states and ERROR response.
//   HCLK bus clock, HRESETn async active-low reset, bus slave modport of ahb_mem_slave_if
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_BYTES   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input logic            HCLK,
  input logic            HRESETn,
  ahb_mem_slave_if.slave bus
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int DEPTH = MEM_BYTES / 4;
  localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  hsize_e          size_q;
  logic [AW-1:0]   off_q;
  logic [31:0]     off, rdata;
  logic [3:0]      be;
  logic            illegal, hready, accept, last;
  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
  assign off     = bus.HADDR - BASE_ADDR;
  assign illegal = off >= 32'(MEM_BYTES) || bus.HSIZE > HS_WORD ||
                   (bus.HSIZE == HS_HALF && bus.HADDR[0]) ||
                   (bus.HSIZE == HS_WORD && bus.HADDR[1:0] != 2'b00);
  assign hready  = !(state_q inside {S_WAIT, S_ERR1});
  assign accept  = hready && bus.HTRANS[1];
  assign last    = cnt_q == 4'(WAIT_STATES - 1);
  always_comb begin
    state_d = !hready ? (state_q == S_ERR1 ? S_ERR2 : last ? S_DATA : S_WAIT)
            : !accept ? S_IDLE
            : illegal ? S_ERR1
            : WAIT_STATES > 0 ? S_WAIT : S_DATA;
    cnt_d   = state_q == S_WAIT && !last ? cnt_q + 4'd1 : 4'd0;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= HS_BYTE;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= bus.HWRITE;
        size_q  <= hsize_e'(bus.HSIZE);
        off_q   <= off[AW-1:0];
      end
    end
  // Writes commit only on the edge that ends an OKAY data phase.
  assign be = state_q != S_DATA || !write_q ? 4'b0000
            : size_q == HS_BYTE ? 4'b0001 << off_q[1:0]
            : size_q == HS_HALF ? (off_q[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
  ahb_mem_slave_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i  (HCLK),
    .we_i   (be),
    .addr_i (IW'(off_q >> 2)),
    .wdata_i(bus.HWDATA),
    .rdata_o(rdata)
  );
  assign bus.HREADY = hready;
  assign bus.HRESP  = state_q inside {S_ERR1, S_ERR2} ? HR_ERROR : HR_OKAY;
  assign bus.HRDATA = state_q == S_DATA && !write_q ? rdata : '0;
  logic unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: directed scoreboard bench over three slaves (0, 2 and 3 wait states).
module tb_ahb_mem_slave;
  import ahb_pkg::*;
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          waits;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [1:0]  htrans = 2'b00, sel = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010, hburst = 3'b000;
  logic [31:0] haddr = '0, hwdata = '0;
  logic        rdy [3];
  logic [1:0]  rsp [3];
  logic [31:0] rdt [3];
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  exp_t        sb [$];
  exp_t        cur;
  int          checks = 0, errors = 0, waits = 0;
  bit          pend = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_mem_slave_if bus ();
    assign bus.HTRANS = sel == 2'(g) ? htrans : 2'b00;
    assign bus.HWRITE = hwrite;
    assign bus.HSIZE  = hsize;
    assign bus.HBURST = hburst;
    assign bus.HADDR  = haddr;
    assign bus.HWDATA = hwdata;
    ahb_mem_slave #(.MEM_BYTES(4096), .BASE_ADDR(32'h0), .WAIT_STATES(g == 0 ? 0 : g + 1)) dut (
      .HCLK   (clk),
      .HRESETn(rst_n),
      .bus    (bus)
    );
    assign rdy[g] = bus.HREADY;
    assign rsp[g] = bus.HRESP;
    assign rdt[g] = bus.HRDATA;
  end

  assign hready = rdy[sel];
  assign hresp  = rsp[sel];
  assign hrdata = rdt[sel];

  function automatic int ws();
    return sel == 2'd0 ? 0 : int'(sel) + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Present one address phase, queue its expected response, return just after it is accepted
  // with HWDATA set for the data phase.
  task automatic xfer(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic err, input logic [31:0] rd);
    int n = 0;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    if (tr[1]) sb.push_back('{err ? 2'b01 : 2'b00, (err || wr) ? 32'h0 : rd, err ? 1 : ws()});
    do begin
      @(negedge clk);
      n++;
    end while (!hready && n < 40);
    if (!hready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h actual=busy required=ready", a);
    end
    @(posedge clk);
    #1;
    htrans = 2'b00;
    if (tr[1]) hwdata = wd;
  endtask

  task automatic idle(input int n);
    htrans = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      sb.delete();
    end else begin
      if (pend && sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=accepted required=none");
        pend = 0;
      end else if (pend && !hready) begin
        waits++;
        chk("wait_resp", 32'(hresp), 32'(sb[0].resp));
        chk("wait_rdata", hrdata, 32'h0);
      end else if (pend) begin
        cur = sb.pop_front();
        chk("beat_resp", 32'(hresp), 32'(cur.resp));
        chk("beat_rdata", hrdata, cur.data);
        chk("beat_waits", 32'(waits), 32'(cur.waits));
        pend = 0;
      end else begin
        chk("idle_ready", 32'(hready), 32'h1);
        chk("idle_resp", 32'(hresp), 32'h0);
        chk("idle_rdata", hrdata, 32'h0);
      end
      if (hready && htrans[1]) begin
        pend  = 1;
        waits = 0;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 32'(rdy[k]), 32'h1);
      chk("reset_resp", 32'(rsp[k]), 32'h0);
      chk("reset_rdata", rdt[k], 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    // zero wait states: write/read, byte and half lanes, errors, pipelined recovery
    sel = 2'd0;
    xfer(2'b10, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer(2'b10, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    xfer(2'b10, 1'b1, 3'b000, 32'h13, 32'hAA00_0000, 1'b0, 32'h0);
    xfer(2'b10, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hAAADBEEF);
    xfer(2'b10, 1'b1, 3'b001, 32'h10, 32'h0000_1234, 1'b0, 32'h0);
    xfer(2'b10, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hAAAD1234);
    xfer(2'b10, 1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
    xfer(2'b10, 1'b1, 3'b010, 32'h0, 32'h01020304, 1'b0, 32'h0);
    xfer(2'b10, 1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(2'b10, 1'b1, 3'b010, 32'h2, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(2'b10, 1'b1, 3'b011, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(2'b10, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(2'b10, 1'b0, 3'b010, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D);
    xfer(2'b10, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h01020304);
    xfer(2'b10, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hAAAD1234);
    idle(3);
    // two wait states: single beats, then INCR4 burst with a BUSY cycle
    sel = 2'd1;
    xfer(2'b10, 1'b1, 3'b010, 32'h20, 32'h0BADCAFE, 1'b0, 32'h0);
    xfer(2'b10, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0BADCAFE);
    hburst = 3'b011;
    xfer(2'b10, 1'b1, 3'b010, 32'h30, 32'hA0A0A0A0, 1'b0, 32'h0);
    xfer(2'b11, 1'b1, 3'b010, 32'h34, 32'hA1A1A1A1, 1'b0, 32'h0);
    xfer(2'b01, 1'b1, 3'b010, 32'h38, 32'h0, 1'b0, 32'h0);
    xfer(2'b11, 1'b1, 3'b010, 32'h38, 32'hA2A2A2A2, 1'b0, 32'h0);
    xfer(2'b11, 1'b1, 3'b010, 32'h3C, 32'hA3A3A3A3, 1'b0, 32'h0);
    xfer(2'b10, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'hA0A0A0A0);
    xfer(2'b11, 1'b0, 3'b010, 32'h34, 32'h0, 1'b0, 32'hA1A1A1A1);
    xfer(2'b11, 1'b0, 3'b010, 32'h38, 32'h0, 1'b0, 32'hA2A2A2A2);
    xfer(2'b11, 1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'hA3A3A3A3);
    hburst = 3'b000;
    idle(6);
    // three wait states: reset during the second wait cycle of a write aborts it
    sel = 2'd2;
    xfer(2'b10, 1'b1, 3'b010, 32'h40, 32'h11223344, 1'b0, 32'h0);
    idle(6);
    xfer(2'b10, 1'b1, 3'b010, 32'h40, 32'h0000_0055, 1'b0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ready", 32'(hready), 32'h1);
    chk("midreset_resp", 32'(hresp), 32'h0);
    chk("midreset_rdata", hrdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    xfer(2'b10, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h11223344);
    idle(6);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    chk("no_pending", 32'(pend), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Synthesizable AHB3-Lite memory slave, i.e. the responder end of the master/slave bus.
- Decodes address phases, drives HREADY/HRESP/HRDATA and backs transfers with an internal byte-addressable RAM.
- Inserts a configurable number of wait states.
- Returns the two-cycle ERROR response for illegal transfers.
- Serves as the DUT/reference responder for the master driver and monitor on the same bus.

Parameters:
- MEM_BYTES, 4096, RAM size in bytes; power of two, >= 4.
- BASE_ADDR, 32'h0000_0000, first byte address decoded; aligned to MEM_BYTES.
- WAIT_STATES, 0, HREADY-low cycles per OKAY data phase; range 0..15.

Ports:
- HCLK  input  1  bus clock; all state changes on posedge.
- HRESETn  input  1  asynchronous, active-low reset.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  000 byte, 001 half, 010 word; larger sizes are illegal.
- HBURST  input  3  accepted, ignored; master supplies every beat address.
- HADDR  input  32  byte address.
- HWDATA  input  32  write data, little-endian byte lanes.
- HREADY  output  1  transfer done / bus ready; also used internally as the address-phase qualifier.
- HRESP  output  2  00 OKAY, 01 ERROR; RETRY/SPLIT are never driven.
- HRDATA  output  32  read data.

Behaviour:
- Reset (async assert, sync deassert):
  - HREADY=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0.
  - RAM contents are not reset.
- Address phase accepted on a posedge where HREADY=1 and HTRANS[1]=1. Capture HWRITE, HSIZE and offset=HADDR-BASE_ADDR into data-phase registers.
- Transfer is illegal if any of:
  - HADDR outside [BASE_ADDR, BASE_ADDR+MEM_BYTES);
  - HSIZE>010;
  - half-word with HADDR[0]=1;
  - word with HADDR[1:0]!=0.
- IDLE/BUSY with HREADY=1: no data phase; next cycle HREADY=1, HRESP=OKAY (zero-wait OKAY).
- FSM states:
  - IDLE: no pending data phase. On a legal accept, go to WAIT if WAIT_STATES>0, else DATA. On an illegal accept, go to ERR1.
  - WAIT: HREADY=0, HRESP=00; counter counts WAIT_STATES cycles, then DATA.
  - DATA: HREADY=1, HRESP=00; completes the beat. A new address phase is accepted on the same edge (pipelined), with transitions as from IDLE; otherwise go to IDLE.
  - ERR1: HREADY=0, HRESP=01 → ERR2.
  - ERR2: HREADY=1, HRESP=01; an address phase may be accepted on the same edge (transitions as from IDLE). Wait states are never added to errors.
- Write commit:
  - RAM is written on the posedge ending DATA, using HWDATA from that cycle.
  - Byte enables: byte = lane offset[1:0]; half = lanes offset[1]*2 +{0,1}; word = all four lanes.
  - Errored transfers never write.
- Read:
  - In DATA, HRDATA = RAM word at offset[addr_msb:2], read combinationally from the array, all 4 lanes driven.
  - HRDATA=0 in every other state and for write beats.
  - A read immediately following a write to the same word returns the new data, with no stall; the write commits before the read data phase.
- Back-to-back with WAIT_STATES=0: HREADY stays 1 continuously, one beat per cycle.
- Reset asserted mid data phase: transfer aborted, no RAM write, outputs return to reset values immediately.

Decomposition:
- Package ahb_pkg holds:
  - enums htrans_e, hresp_e (OKAY/ERROR/RETRY/SPLIT, 2-bit), hsize_e, hburst_e;
  - constant AHB_DATA_W=32.
- One sub-module, ahb_mem_slave_ram: word-organised RAM with 4 byte-write enables, synchronous write and asynchronous read; parameter DEPTH=MEM_BYTES/4.
- FSM, decode and lane logic live in the top.

Test Plan:
- Reset: hold HRESETn=0 for 3 cycles → HREADY=1, HRESP=00, HRDATA=0; release → stays idle OKAY with HTRANS=IDLE.
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then read @0x10 in the next cycle → HREADY never 0; read data phase HRDATA=0xDEADBEEF, HRESP=00.
- Byte write @0x13 with HWDATA=0xAA00_0000, then word read @0x10 → HRDATA=0xAAADBEEF; half write 0x1234 @0x10 (lanes 0-1) → read 0xAAAD1234.
- WAIT_STATES=2: word read @0x20 → HREADY=0 for exactly 2 cycles, then HREADY=1 with data; 4-beat INCR SEQ burst with one BUSY → each beat 3 cycles, BUSY gets a zero-wait OKAY.
- MEM_BYTES=4096, write @0x1000 → cycle1 HREADY=0/HRESP=01, cycle2 HREADY=1/HRESP=01. Word write @0x2 and HSIZE=011 give the same response. Following read @0xFFC → unchanged data, HRESP=00.
- WAIT_STATES=3: pull HRESETn low during the 2nd wait cycle of a write 0x55 @0x40 → outputs reset at once; read @0x40 after release returns prior contents.
